student_arbmux: RTL and testbench
=================================

Name: student_arbmux

Overview:
Parametrised N-channel, WIDTH-bit arbitrating multiplexer with a registered output. It is the sequential successor to the combinational mux16/mux4way16/mux8way16 family. Select is no longer an input: an internal round-robin or fixed-priority arbiter picks among requesting channels. Handshake is valid/ready on every input and on the output. It sits between several producers (e.g. CPU/memory-mapped sources) and one shared consumer.

Parameters:
WIDTH, 16, data bits per channel (1..64)
N, 4, number of input channels (2..16)
RR, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins)
SELW, derived = max(1, clog2(N)), width of the channel index; localparam, not overridable

Ports:
clk  input  1  rising-edge clock, the only clock
reset  input  1  synchronous, active-high reset
in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  N  channel i presents a word
in_ready  output  N  channel i's word is taken this cycle
out_data  output  WIDTH  registered output word
out_sel  output  SELW  index of the channel that supplied out_data
out_valid  output  1  out_data/out_sel hold a word
out_ready  input  1  consumer takes the word this cycle

Behaviour:
- One clock (clk). Reset is synchronous and active-high: sampled only on the rising edge of clk.
- Reset values: out_valid=0, out_data=0, out_sel=0, rr pointer ptr=0. While reset=1, in_ready=all-0.
- A transfer occurs on any edge where valid && ready, on either side.
- can_load = !out_valid || out_ready. The output register is empty, or it is being drained this cycle.
- Grant (combinational):
  - RR=1: first index i with in_valid[i], searched ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (mod N).
  - RR=0: lowest index i with in_valid[i]; ptr is ignored.
- in_ready[i] = !reset && can_load && in_valid[i] && (grant==i). At most one bit is set (one-hot or zero).
- Load edge (can_load && |in_valid): out_data <= granted word, out_sel <= grant, out_valid <= 1. When RR=1, ptr <= (grant==N-1) ? 0 : grant+1.
- Drain-only edge (out_valid && out_ready && no in_valid): out_valid <= 0. out_data and out_sel keep their old values.
- Stall (out_valid && !out_ready): out_data, out_sel and out_valid are held stable. in_ready=0. ptr is unchanged.
- Latency is 1 cycle from input acceptance to out_valid. Throughput is 1 word/cycle with out_ready tied high. No bubble when drain and load happen on the same edge.
- ptr advances only on a grant, never on idle cycles. Wrap: a grant to N-1 sets ptr to 0.
- in_valid may drop without a transfer. The arbiter re-evaluates every cycle; there is no grant lock.
- Reset mid-operation: a held word is discarded (out_valid=0 on the next edge) and ptr returns to 0.
- N not a power of two: out_sel never exceeds N-1. Unused index codes are unreachable.

Decomposition:
- Shared header/package: the clog2-based SELW helper function and the arbitration-mode constants (ARB_FIXED=0, ARB_RR=1). Both are reused by later multi-source blocks.
- One sub-module: student_rr_arbiter (N, RR).
  - Inputs: req[N], ptr[SELW].
  - Outputs: grant index, any_req.
  - Purely combinational.
- The top level holds ptr, the output register and the handshake logic. Data selection reuses the indexed part-select of in_data.

Test Plan:
1. Reset: hold reset=1 for 2 cycles with all in_valid=1 -> in_ready=0000, out_valid=0, out_data=0x0000, out_sel=0. After release, the first grant is channel 0.
2. Single request: N=4, in_valid=0010, ch1=0xBEEF, out_ready=1 -> in_ready=0010 that cycle. Next cycle out_valid=1, out_data=0xBEEF, out_sel=1, ptr=2.
3. Round-robin fairness and wrap: all in_valid=1111, ch i data=0x1000+i, out_ready=1 for 6 cycles -> out_sel sequence 0,1,2,3,0,1 back-to-back with no bubbles.
4. Backpressure: word 0xBEEF held with out_ready=0 for 3 cycles while in_valid=1111 -> out_data, out_sel and out_valid are stable, in_ready=0000 and ptr is unchanged. Raise out_ready -> same-edge drain and load of the next RR channel.
5. Fixed priority: RR=0, in_valid=1111 continuously, out_ready=1 -> out_sel=0 every cycle. Drop in_valid[0] -> out_sel=1 the following cycle.
6. Reset mid-stream: assert reset for 1 cycle while out_valid=1 and ptr=2 -> next edge out_valid=0 and ptr=0. The next grant with in_valid=1111 is channel 0.

Source files
------------

// File: rtl/student_arbmux_pkg.sv
// Shared definitions for multi-source arbitrating blocks: arbitration
// mode codes and the channel-index width helper.
package student_arbmux_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Width of a channel index for n channels, never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/student_rr_arbiter.sv
// Combinational arbiter: picks one requesting channel, either rotating
// from a start pointer (round-robin) or lowest index first (fixed).
module student_rr_arbiter
    import student_arbmux_pkg::*;
#(
    parameter int N  = 4,
    parameter int RR = ARB_RR,
    localparam int SELW = sel_width(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] grant,
    output logic            any_req
);

    int              idx;
    logic [SELW-1:0] cand;
    logic            found;

    // Scan channels starting at ptr (or 0 in fixed mode), wrapping modulo N;
    // the first requester seen wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            idx = (RR == ARB_RR) ? int'(ptr) + k : k;
            if (idx >= N) begin
                idx = idx - N;
            end
            cand = SELW'(idx);
            if (!found && req[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/student_arbmux.sv
// N-channel arbitrating multiplexer with a single registered output stage
// and valid/ready handshakes on every input and on the output.
module student_arbmux
    import student_arbmux_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    parameter int RR    = ARB_RR,
    localparam int SELW = sel_width(N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [SELW-1:0]  grant;
    logic [SELW-1:0]  ptr;
    logic             any_req;
    logic             can_load;
    logic             load;

    logic [WIDTH-1:0] data_p1;
    logic [SELW-1:0]  sel_p1;
    logic             vld_p1;

    student_rr_arbiter #(
        .N  (N),
        .RR (RR)
    ) u_arb (
        .req     (in_valid),
        .ptr     (ptr),
        .grant   (grant),
        .any_req (any_req)
    );

    // The output slot can accept a word when empty or when it drains this
    // same edge, which gives back-to-back transfers with no bubble.
    assign can_load = !vld_p1 || out_ready;
    assign load     = can_load && any_req;

    // Only the granted channel sees ready, and only on a load edge.
    always_comb begin
        in_ready = '0;
        if (!reset && load) begin
            in_ready[grant] = 1'b1;
        end
    end

    // ---- stage p0 -> p1: output register and rotation pointer ----
    // Load the granted word, drain an empty-handed slot, or hold under stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            sel_p1  <= '0;
            ptr     <= '0;
        end else if (load) begin
            vld_p1  <= 1'b1;
            data_p1 <= in_data[int'(grant)*WIDTH +: WIDTH];
            sel_p1  <= grant;
            if (RR == ARB_RR) begin
                ptr <= (grant == SELW'(N - 1)) ? '0 : grant + SELW'(1);
            end
        end else if (vld_p1 && out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_data  = data_p1;
    assign out_sel   = sel_p1;
    assign out_valid = vld_p1;

endmodule

// File: tb/tb_student_arbmux.sv
// Directed bench for student_arbmux: a round-robin and a fixed-priority
// instance share the same stimulus; expected values are hand-derived.
module tb_student_arbmux;

    localparam int WIDTH = 16;
    localparam int N     = 4;
    localparam int SELW  = 2;

    logic                 clk;
    logic                 reset;
    logic [N*WIDTH-1:0]   in_data;
    logic [N-1:0]         in_valid;
    logic                 out_ready;

    logic [N-1:0]         in_ready_rr, in_ready_fx;
    logic [WIDTH-1:0]     out_data_rr, out_data_fx;
    logic [SELW-1:0]      out_sel_rr,  out_sel_fx;
    logic                 out_valid_rr, out_valid_fx;

    int n_cmp;
    int n_err;

    student_arbmux #(.WIDTH(WIDTH), .N(N), .RR(1)) dut_rr (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready_rr),
        .out_data  (out_data_rr),
        .out_sel   (out_sel_rr),
        .out_valid (out_valid_rr),
        .out_ready (out_ready)
    );

    student_arbmux #(.WIDTH(WIDTH), .N(N), .RR(0)) dut_fx (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready_fx),
        .out_data  (out_data_fx),
        .out_sel   (out_sel_fx),
        .out_valid (out_valid_fx),
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_ch(input int i, input logic [WIDTH-1:0] val);
        in_data[i*WIDTH +: WIDTH] = val;
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        in_data   = '0;
        in_valid  = '0;
        out_ready = 1'b1;
        reset     = 1'b1;
        for (int i = 0; i < N; i++) set_ch(i, 16'(16'h1000 + i));

        // 1. Reset with every channel requesting
        in_valid = 4'b1111;
        #1;
        check("rst_in_ready_rr", 64'(in_ready_rr), 64'h0);
        check("rst_in_ready_fx", 64'(in_ready_fx), 64'h0);
        step();
        step();
        check("rst_in_ready_hold", 64'(in_ready_rr), 64'h0);
        check("rst_out_valid", 64'(out_valid_rr), 64'h0);
        check("rst_out_data", 64'(out_data_rr), 64'h0);
        check("rst_out_sel", 64'(out_sel_rr), 64'h0);
        check("rst_ptr", 64'(dut_rr.ptr), 64'h0);
        reset = 1'b0;
        #1;
        check("first_grant_rr", 64'(in_ready_rr), 64'b0001);
        check("first_grant_fx", 64'(in_ready_fx), 64'b0001);
        in_valid = 4'b0000;
        step();
        check("idle_out_valid", 64'(out_valid_rr), 64'h0);
        check("idle_ptr", 64'(dut_rr.ptr), 64'h0);

        // 2. Single request on channel 1
        set_ch(1, 16'hBEEF);
        in_valid = 4'b0010;
        #1;
        check("single_in_ready", 64'(in_ready_rr), 64'b0010);
        step();
        check("single_out_valid", 64'(out_valid_rr), 64'h1);
        check("single_out_data", 64'(out_data_rr), 64'hBEEF);
        check("single_out_sel", 64'(out_sel_rr), 64'h1);
        check("single_ptr", 64'(dut_rr.ptr), 64'h2);
        // Drain-only edge keeps data/sel and the pointer
        in_valid = 4'b0000;
        step();
        check("drain_out_valid", 64'(out_valid_rr), 64'h0);
        check("drain_out_data", 64'(out_data_rr), 64'hBEEF);
        check("drain_out_sel", 64'(out_sel_rr), 64'h1);
        check("drain_ptr", 64'(dut_rr.ptr), 64'h2);
        set_ch(1, 16'h1001);

        // Reset between tests brings ptr back to 0
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst2_ptr", 64'(dut_rr.ptr), 64'h0);

        // 3. Round-robin fairness and wrap; fixed priority always picks 0
        in_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("rr_in_ready", 64'(in_ready_rr), 64'(1 << (k % 4)));
            step();
            check("rr_out_valid", 64'(out_valid_rr), 64'h1);
            check("rr_out_sel", 64'(out_sel_rr), 64'(k % 4));
            check("rr_out_data", 64'(out_data_rr), 64'(16'h1000 + (k % 4)));
            check("fx_out_sel", 64'(out_sel_fx), 64'h0);
        end
        check("rr_ptr_after6", 64'(dut_rr.ptr), 64'h2);

        // 4. Backpressure: load 0xBEEF from channel 2, then stall 3 cycles
        set_ch(2, 16'hBEEF);
        step();
        check("bp_load_data", 64'(out_data_rr), 64'hBEEF);
        check("bp_load_sel", 64'(out_sel_rr), 64'h2);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_in_ready", 64'(in_ready_rr), 64'h0);
            step();
            check("bp_out_valid", 64'(out_valid_rr), 64'h1);
            check("bp_out_data", 64'(out_data_rr), 64'hBEEF);
            check("bp_out_sel", 64'(out_sel_rr), 64'h2);
            check("bp_ptr", 64'(dut_rr.ptr), 64'h3);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 64'(in_ready_rr), 64'b1000);
        step();
        check("bp_release_valid", 64'(out_valid_rr), 64'h1);
        check("bp_release_sel", 64'(out_sel_rr), 64'h3);
        check("bp_release_data", 64'(out_data_rr), 64'h1003);
        check("bp_release_ptr", 64'(dut_rr.ptr), 64'h0);

        // 5. Fixed priority moves to channel 1 once channel 0 drops
        in_valid = 4'b1110;
        #1;
        check("fx_drop0_in_ready", 64'(in_ready_fx), 64'b0010);
        step();
        check("fx_drop0_sel", 64'(out_sel_fx), 64'h1);
        check("fx_drop0_data", 64'(out_data_fx), 64'h1001);
        check("rr_drop0_sel", 64'(out_sel_rr), 64'h1);
        check("rr_drop0_ptr", 64'(dut_rr.ptr), 64'h2);

        // 6. Reset mid-stream while a word is held and ptr=2
        in_valid = 4'b1111;
        reset = 1'b1;
        #1;
        check("mid_rst_in_ready", 64'(in_ready_rr), 64'h0);
        step();
        check("mid_rst_out_valid", 64'(out_valid_rr), 64'h0);
        check("mid_rst_ptr", 64'(dut_rr.ptr), 64'h0);
        reset = 1'b0;
        #1;
        check("mid_rst_grant", 64'(in_ready_rr), 64'b0001);
        step();
        check("mid_rst_next_sel", 64'(out_sel_rr), 64'h0);
        check("mid_rst_next_data", 64'(out_data_rr), 64'h1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
